// File: rtl/iob_ram_responder_if.sv
// IOb native bus bundle: initiator drives the request, responder returns data and ready.
interface iob_ram_responder_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32
);
    logic                  valid;
    logic [ADDR_W-1:0]     address;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W/8-1:0]   wstrb;
    logic [DATA_W-1:0]     rdata;
    logic                  ready;

    modport master (
        output valid, address, wdata, wstrb,
        input  rdata, ready
    );

    modport slave (
        input  valid, address, wdata, wstrb,
        output rdata, ready
    );
endinterface

// File: rtl/iob_ram_responder.sv
// IOb responder backed by a word-addressed RAM with programmable response latency.
// One outstanding request; request fields are captured on accept.
module iob_ram_responder #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned MEM_ADDR_W = 10,
    parameter int unsigned LATENCY    = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    iob_ram_responder_if.slave   io_bus
);

    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned CNT_W  = $clog2(LATENCY + 1);
    localparam int unsigned DEPTH  = 2 ** MEM_ADDR_W;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]            r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [MEM_ADDR_W-1:0] r_idx;
    logic [DATA_W-1:0]     r_wdata;
    logic [STRB_W-1:0]     r_wstrb;
    logic [DATA_W-1:0]     r_rdata;
    logic [DATA_W-1:0]     r_mem [DEPTH];

    logic [1:0]            w_next_state;
    logic [CNT_W-1:0]      w_next_cnt;
    logic                  w_accept;
    logic [MEM_ADDR_W-1:0] w_bus_idx;
    logic [MEM_ADDR_W-1:0] w_rd_idx;
    logic                  w_rd_is_read;
    logic                  w_enter_resp;
    logic                  w_unused_addr;

    // Upper address bits and the byte offset alias onto the same word.
    assign w_bus_idx     = io_bus.address[MEM_ADDR_W+1:2];
    assign w_unused_addr = ^io_bus.address;
    assign w_accept      = (r_state == ST_IDLE) && io_bus.valid;

    // With LATENCY=1 the RAM read happens on the accept edge, before the fields are latched.
    assign w_rd_idx      = (r_state == ST_IDLE) ? w_bus_idx : r_idx;
    assign w_rd_is_read  = (r_state == ST_IDLE) ? (io_bus.wstrb == '0) : (r_wstrb == '0);
    assign w_enter_resp  = (w_next_state == ST_RESP) && (r_state != ST_RESP);

    // Next-state and latency counter logic.
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (io_bus.valid) begin
                    w_next_cnt   = CNT_W'(LATENCY - 1);
                    w_next_state = (LATENCY == 1) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                // Valid is not rechecked here: an accepted request always completes.
                if (r_cnt <= CNT_W'(1)) begin
                    w_next_cnt   = '0;
                    w_next_state = ST_RESP;
                end else begin
                    w_next_cnt = r_cnt - CNT_W'(1);
                end
            end
            ST_RESP: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
                w_next_cnt   = '0;
            end
        endcase
    end

    // FSM state and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
        end
    end

    // Capture request fields on accept; later bus changes are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx   <= '0;
            r_wdata <= '0;
            r_wstrb <= '0;
        end else if (w_accept) begin
            r_idx   <= w_bus_idx;
            r_wdata <= io_bus.wdata;
            r_wstrb <= io_bus.wstrb;
        end
    end

    // Read data registered on the edge entering RESP; held across write responses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= '0;
        end else if (w_enter_resp && w_rd_is_read) begin
            r_rdata <= r_mem[w_rd_idx];
        end
    end

    // Byte-masked write on the RESP edge; reset forces IDLE so a pending write is dropped.
    always_ff @(posedge clk) begin
        if ((r_state == ST_RESP) && (r_wstrb != '0)) begin
            for (int i = 0; i < int'(STRB_W); i++) begin
                if (r_wstrb[i]) begin
                    r_mem[r_idx][i*8 +: 8] <= r_wdata[i*8 +: 8];
                end
            end
        end
    end

    assign io_bus.ready = (r_state == ST_RESP);
    assign io_bus.rdata = r_rdata;

endmodule

// File: tb/tb_iob_ram_responder.sv
// Directed bench for iob_ram_responder at LATENCY 1, 2 and 4.
module tb_iob_ram_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        rst_n4;
    logic        v1, v2, v4;
    logic [31:0] t_addr;
    logic [31:0] t_wdata;
    logic [3:0]  t_wstrb;

    int n_checks = 0;
    int n_fail   = 0;

    iob_ram_responder_if #(.DATA_W(32), .ADDR_W(32)) bus1 ();
    iob_ram_responder_if #(.DATA_W(32), .ADDR_W(32)) bus2 ();
    iob_ram_responder_if #(.DATA_W(32), .ADDR_W(32)) bus4 ();

    assign bus1.valid = v1;
    assign bus1.address = t_addr;
    assign bus1.wdata = t_wdata;
    assign bus1.wstrb = t_wstrb;
    assign bus2.valid = v2;
    assign bus2.address = t_addr;
    assign bus2.wdata = t_wdata;
    assign bus2.wstrb = t_wstrb;
    assign bus4.valid = v4;
    assign bus4.address = t_addr;
    assign bus4.wdata = t_wdata;
    assign bus4.wstrb = t_wstrb;

    iob_ram_responder #(.DATA_W(32), .ADDR_W(32), .MEM_ADDR_W(10), .LATENCY(1)) u_lat1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_bus (bus1)
    );

    iob_ram_responder #(.DATA_W(32), .ADDR_W(32), .MEM_ADDR_W(10), .LATENCY(2)) u_lat2 (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_bus (bus2)
    );

    iob_ram_responder #(.DATA_W(32), .ADDR_W(32), .MEM_ADDR_W(10), .LATENCY(4)) u_lat4 (
        .clk    (clk),
        .rst_n  (rst_n4),
        .io_bus (bus4)
    );

    function automatic logic sel_ready(input int inst);
        case (inst)
            1:       return bus1.ready;
            2:       return bus2.ready;
            default: return bus4.ready;
        endcase
    endfunction

    function automatic logic [31:0] sel_rdata(input int inst);
        case (inst)
            1:       return bus1.rdata;
            2:       return bus2.rdata;
            default: return bus4.rdata;
        endcase
    endfunction

    task automatic set_valid(input int inst, input logic val);
        case (inst)
            1:       v1 = val;
            2:       v2 = val;
            default: v4 = val;
        endcase
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // mode 0: plain; mode 1: perturb fields after accept; mode 2: drop valid after accept.
    task automatic req(input int inst, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [3:0] ws, input int mode,
                       output int lat, output logic [31:0] rd);
        @(negedge clk);
        t_addr  = addr;
        t_wdata = wd;
        t_wstrb = ws;
        set_valid(inst, 1'b1);
        lat = -1;
        rd  = 'x;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            #1;
            if (n == 1 && mode == 1) begin
                t_addr  = 32'h20;
                t_wdata = 32'h0;
                t_wstrb = 4'hF;
            end
            if (n == 1 && mode == 2) set_valid(inst, 1'b0);
            if (sel_ready(inst)) begin
                lat = n;
                rd  = sel_rdata(inst);
                break;
            end
        end
        set_valid(inst, 1'b0);
        @(posedge clk);
        #1;
        check("single_cycle_ready", {31'b0, sel_ready(inst)}, 32'h0);
    endtask

    initial begin
        int          lat;
        logic [31:0] rd;
        logic [31:0] exp_b2b [3];
        logic [5:0]  rmask;
        int          bidx;

        rst_n   = 1'b0;
        rst_n4  = 1'b0;
        v1      = 1'b0;
        v2      = 1'b0;
        v4      = 1'b0;
        t_addr  = '0;
        t_wdata = '0;
        t_wstrb = '0;
        #1;
        check("reset_ready_l1", {31'b0, bus1.ready}, 32'h0);
        check("reset_rdata_l2", bus2.rdata, 32'h0);
        check("reset_ready_l4", {31'b0, bus4.ready}, 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n  = 1'b1;
        rst_n4 = 1'b1;

        // Latency 2 write then read.
        req(2, 32'h10, 32'hDEADBEEF, 4'hF, 0, lat, rd);
        check("l2_write_latency", 32'(lat), 32'd2);
        req(2, 32'h10, 32'h0, 4'h0, 0, lat, rd);
        check("l2_read_latency", 32'(lat), 32'd2);
        check("l2_read_data", rd, 32'hDEADBEEF);
        req(2, 32'h14, 32'h12345678, 4'hF, 0, lat, rd);
        check("write_keeps_rdata", rd, 32'hDEADBEEF);

        // Byte strobes.
        req(2, 32'h20, 32'h11223344, 4'hF, 0, lat, rd);
        req(2, 32'h20, 32'hAABBCCDD, 4'h5, 0, lat, rd);
        req(2, 32'h20, 32'h0, 4'h0, 0, lat, rd);
        check("byte_strobe_merge", rd, 32'h11BB33DD);

        // Address aliasing.
        req(2, 32'h1004, 32'h5A5A5A5A, 4'hF, 0, lat, rd);
        req(2, 32'h0004, 32'h0, 4'h0, 0, lat, rd);
        check("alias_read", rd, 32'h5A5A5A5A);
        req(2, 32'h14, 32'h0, 4'h0, 0, lat, rd);
        check("readback_0x14", rd, 32'h12345678);

        // Fields changed during WAIT are ignored.
        req(2, 32'h10, 32'h0, 4'h0, 1, lat, rd);
        check("latched_addr_lat", 32'(lat), 32'd2);
        check("latched_addr_data", rd, 32'hDEADBEEF);
        req(2, 32'h20, 32'h0, 4'h0, 0, lat, rd);
        check("late_wstrb_ignored", rd, 32'h11BB33DD);

        // Valid dropped in WAIT still completes.
        req(2, 32'h4, 32'h0, 4'h0, 2, lat, rd);
        check("dropped_valid_lat", 32'(lat), 32'd2);
        check("dropped_valid_data", rd, 32'h5A5A5A5A);

        // Latency 1 back-to-back reads with valid held.
        exp_b2b[0] = 32'hA0A0A0A0;
        exp_b2b[1] = 32'hA4A4A4A4;
        exp_b2b[2] = 32'hA8A8A8A8;
        for (int k = 0; k < 3; k++) begin
            req(1, 32'(k * 4), exp_b2b[k], 4'hF, 0, lat, rd);
            check("l1_write_latency", 32'(lat), 32'd1);
        end
        @(negedge clk);
        t_addr  = 32'h0;
        t_wstrb = 4'h0;
        v1      = 1'b1;
        bidx    = 0;
        rmask   = '0;
        for (int e = 0; e < 6; e++) begin
            @(posedge clk);
            #1;
            rmask[e] = bus1.ready;
            if (bus1.ready && bidx < 3) begin
                check("b2b_rdata", bus1.rdata, exp_b2b[bidx]);
                bidx++;
                t_addr = 32'(bidx * 4);
                if (bidx == 3) v1 = 1'b0;
            end
        end
        v1 = 1'b0;
        check("b2b_ready_pattern", {26'b0, rmask}, 32'h15);
        check("b2b_count", 32'(bidx), 32'd3);

        // Latency 4 reset mid-write.
        req(4, 32'h30, 32'h01234567, 4'hF, 0, lat, rd);
        check("l4_write_latency", 32'(lat), 32'd4);
        @(negedge clk);
        t_addr  = 32'h30;
        t_wdata = 32'hFFFFFFFF;
        t_wstrb = 4'hF;
        v4      = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n4 = 1'b0;
        v4     = 1'b0;
        #1;
        check("reset_midop_ready", {31'b0, bus4.ready}, 32'h0);
        for (int e = 0; e < 4; e++) begin
            @(posedge clk);
            #1;
            check("reset_hold_ready", {31'b0, bus4.ready}, 32'h0);
        end
        @(negedge clk);
        rst_n4 = 1'b1;
        req(4, 32'h30, 32'h0, 4'h0, 0, lat, rd);
        check("l4_read_latency", 32'(lat), 32'd4);
        check("discarded_write", rd, 32'h01234567);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
